// File: rtl/ila_trig_pkg.sv
// Shared types and register offsets for the ila_trig logic analyzer.
// Offsets are relative to BASE_ILA (0xf810_0000); bus_sel decodes the region.
package ila_trig_pkg;

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} ila_state_t;

  // Trigger register targeted by a buffered bus write
  typedef enum logic [1:0] {TR_MASK, TR_VALUE, TR_POST} trig_reg_t;

  localparam logic [7:0] ILA_VERSION = 8'd2;

  localparam logic [19:0] R_ILA_INFO       = 20'h8_0000;
  localparam logic [19:0] R_ILA_CTRL       = 20'h8_0004;
  localparam logic [19:0] R_ILA_TRIG_MASK  = 20'h8_0008;
  localparam logic [19:0] R_ILA_TRIG_VALUE = 20'h8_000C;
  localparam logic [19:0] R_ILA_POST_CNT   = 20'h8_0010;
  localparam logic [19:0] R_ILA_TRIG_IDX   = 20'h8_0014;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_STOP_BIT  = 1;
  localparam int CTRL_CLEAR_BIT = 2;
  localparam int CTRL_EDGE_BIT  = 4;

endpackage

// File: rtl/ila_trig_sample_ram.sv
// Circular sample store: one write port for capture, one registered read port
// for the bus. Written so synthesis maps it onto block RAM.
module ila_trig_sample_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ila_trig.sv
// Integrated logic analyzer with masked level/edge trigger and post-trigger count.
// Bus: a request is bus_valid&bus_sel while bus_ready is low; bus_ready pulses one cycle later.
module ila_trig
  import ila_trig_pkg::*;
#(
  parameter int SAMPLE_W   = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] probe,
  input  logic                bus_valid,
  input  logic [31:0]         bus_addr,
  input  logic                bus_we,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata,
  output logic                bus_ready,
  input  logic                bus_sel
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] POST_RST = DEPTH_LOG2'(DEPTH / 2);

  ila_state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]     pre_cnt_q, pre_cnt_d;
  logic [DEPTH_LOG2-1:0]     remaining_q, remaining_d;
  logic [DEPTH_LOG2-1:0]     trig_idx_q, trig_idx_d;
  logic [DEPTH_LOG2-1:0]     post_cnt_q, post_cnt_d;
  logic [SAMPLE_W-1:0]       trig_mask_q, trig_mask_d;
  logic [SAMPLE_W-1:0]       trig_value_q, trig_value_d;
  logic                      edge_mode_q, edge_mode_d;
  logic                      match_q, match_d;
  logic                      triggered_q, triggered_d;
  logic                      pend_we_q, pend_we_d;
  trig_reg_t                 pend_sel_q, pend_sel_d;
  logic [31:0]               pend_data_q, pend_data_d;
  logic                      bus_ready_q, bus_ready_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      ram_rd_q, ram_rd_d;

  logic [19:0]               offs;
  logic                      req, wr_req, ctrl_wr, ram_hit;
  logic                      cmd_clear, cmd_stop, cmd_arm;
  logic                      capturing, match, hit;
  logic [DEPTH_LOG2-1:0]     post_eff, pre_target;
  logic [SAMPLE_W-1:0]       ram_rd_data;
  logic                      unused_addr;

  assign offs      = bus_addr[19:0];
  assign req       = bus_valid & bus_sel & ~bus_ready_q;
  assign wr_req    = req & bus_we;
  assign ram_hit   = ~offs[19] && (offs[18:DEPTH_LOG2+2] == '0);
  assign ctrl_wr   = wr_req && (offs == R_ILA_CTRL);
  assign cmd_clear = ctrl_wr & bus_wdata[CTRL_CLEAR_BIT];
  assign cmd_stop  = ctrl_wr & bus_wdata[CTRL_STOP_BIT] & ~bus_wdata[CTRL_CLEAR_BIT];
  assign cmd_arm   = ctrl_wr & bus_wdata[CTRL_ARM_BIT] & ~bus_wdata[CTRL_STOP_BIT]
                   & ~bus_wdata[CTRL_CLEAR_BIT];
  assign unused_addr = ^bus_addr[31:20];

  assign capturing  = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
  assign match      = ((probe ^ trig_value_q) & trig_mask_q) == '0;
  assign hit        = match & ~(edge_mode_q & match_q);
  assign post_eff   = (post_cnt_q == '0) ? PTR_ONE : post_cnt_q;
  // DEPTH - post_eff, taken modulo DEPTH; post_eff >= 1 keeps it non-zero
  assign pre_target = DEPTH_LOG2'(DEPTH - int'(post_eff));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    remaining_d  = remaining_q;
    trig_idx_d   = trig_idx_q;
    triggered_d  = triggered_q;
    match_d      = match_q;
    trig_mask_d  = trig_mask_q;
    trig_value_d = trig_value_q;
    post_cnt_d   = post_cnt_q;
    edge_mode_d  = edge_mode_q;
    pend_we_d    = 1'b0;
    pend_sel_d   = pend_sel_q;
    pend_data_d  = pend_data_q;
    bus_ready_d  = req;
    rdata_d      = '0;
    ram_rd_d     = 1'b0;

    if (capturing) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      match_d  = match;
    end

    case (state_q)
      PRE: begin
        pre_cnt_d = pre_cnt_q + PTR_ONE;
        if (pre_cnt_d == pre_target) state_d = WAIT;
      end
      WAIT: begin
        if (hit) begin
          trig_idx_d  = wr_ptr_q;
          triggered_d = 1'b1;
          remaining_d = post_eff - PTR_ONE;
          state_d     = (post_eff == PTR_ONE) ? DONE : POST;
        end
      end
      POST: begin
        remaining_d = remaining_q - PTR_ONE;
        if (remaining_q == PTR_ONE) state_d = DONE;
      end
      default: ;
    endcase

    if (cmd_clear) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
      wr_ptr_d    = '0;
      match_d     = 1'b0;
    end else if (cmd_stop && capturing) begin
      state_d     = DONE;
      triggered_d = 1'b0;
    end else if (cmd_arm) begin
      state_d     = PRE;
      triggered_d = 1'b0;
      wr_ptr_d    = '0;
      pre_cnt_d   = '0;
      match_d     = 1'b0;
    end
    if (ctrl_wr) edge_mode_d = bus_wdata[CTRL_EDGE_BIT];

    // Trigger registers are buffered one cycle so they change after bus_ready
    if (wr_req) begin
      pend_data_d = bus_wdata;
      case (offs)
        R_ILA_TRIG_MASK:  begin pend_we_d = 1'b1; pend_sel_d = TR_MASK;  end
        R_ILA_TRIG_VALUE: begin pend_we_d = 1'b1; pend_sel_d = TR_VALUE; end
        R_ILA_POST_CNT:   begin pend_we_d = 1'b1; pend_sel_d = TR_POST;  end
        default: ;
      endcase
    end
    if (pend_we_q) begin
      case (pend_sel_q)
        TR_MASK:  trig_mask_d  = pend_data_q[SAMPLE_W-1:0];
        TR_VALUE: trig_value_d = pend_data_q[SAMPLE_W-1:0];
        TR_POST:  post_cnt_d   = pend_data_q[DEPTH_LOG2-1:0];
        default: ;
      endcase
    end

    if (req && !bus_we) begin
      if (ram_hit) begin
        ram_rd_d = 1'b1;
      end else begin
        case (offs)
          R_ILA_INFO:       rdata_d = {8'h00, ILA_VERSION, 8'(DEPTH_LOG2), 8'(SAMPLE_W)};
          R_ILA_CTRL:       rdata_d = {16'(wr_ptr_q), 11'd0, edge_mode_q, 1'b0,
                                       state_q == DONE, triggered_q, capturing};
          R_ILA_TRIG_MASK:  rdata_d = 32'(trig_mask_q);
          R_ILA_TRIG_VALUE: rdata_d = 32'(trig_value_q);
          R_ILA_POST_CNT:   rdata_d = 32'(post_cnt_q);
          R_ILA_TRIG_IDX:   rdata_d = 32'(trig_idx_q);
          default:          rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      remaining_q  <= '0;
      trig_idx_q   <= '0;
      post_cnt_q   <= POST_RST;
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      edge_mode_q  <= 1'b0;
      match_q      <= 1'b0;
      triggered_q  <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_sel_q   <= TR_MASK;
      pend_data_q  <= '0;
      bus_ready_q  <= 1'b0;
      rdata_q      <= '0;
      ram_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      remaining_q  <= remaining_d;
      trig_idx_q   <= trig_idx_d;
      post_cnt_q   <= post_cnt_d;
      trig_mask_q  <= trig_mask_d;
      trig_value_q <= trig_value_d;
      edge_mode_q  <= edge_mode_d;
      match_q      <= match_d;
      triggered_q  <= triggered_d;
      pend_we_q    <= pend_we_d;
      pend_sel_q   <= pend_sel_d;
      pend_data_q  <= pend_data_d;
      bus_ready_q  <= bus_ready_d;
      rdata_q      <= rdata_d;
      ram_rd_q     <= ram_rd_d;
    end
  end

  ila_trig_sample_ram #(
    .W  (SAMPLE_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we      (capturing),
    .wr_addr (wr_ptr_q),
    .wr_data (probe),
    .rd_addr (offs[DEPTH_LOG2+1:2]),
    .rd_data (ram_rd_data)
  );

  assign bus_ready = bus_ready_q;
  assign bus_rdata = !bus_ready_q ? '0 : (ram_rd_q ? 32'(ram_rd_data) : rdata_q);

endmodule

// File: tb/tb_ila_trig.sv
// Directed bench for ila_trig (8-bit probe, 16-deep RAM) with hand-computed expectations.
module tb_ila_trig;

  localparam int SW = 8;
  localparam int DL = 4;
  localparam logic [31:0] A_RAM   = 32'hf810_0000;
  localparam logic [31:0] A_INFO  = 32'hf818_0000;
  localparam logic [31:0] A_CTRL  = 32'hf818_0004;
  localparam logic [31:0] A_MASK  = 32'hf818_0008;
  localparam logic [31:0] A_VALUE = 32'hf818_000C;
  localparam logic [31:0] A_POST  = 32'hf818_0010;
  localparam logic [31:0] A_IDX   = 32'hf818_0014;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] probe;
  logic          bus_valid = 1'b0;
  logic [31:0]   bus_addr = '0;
  logic          bus_we = 1'b0;
  logic [31:0]   bus_wdata = '0;
  logic [31:0]   bus_rdata;
  logic          bus_ready;
  logic          bus_sel = 1'b1;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned base_cyc = 0;
  logic        use_ovr = 1'b0;
  logic [7:0]  probe_ovr = '0;
  logic        mon_en = 1'b0;
  logic        exp_rdy = 1'b0;

  ila_trig #(.SAMPLE_W(SW), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst       (rst),
    .probe     (probe),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_sel   (bus_sel)
  );

  // clock / probe source
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign probe = use_ovr ? probe_ovr : 8'(cyc - base_cyc);

  // bus_ready must follow every accepted request by exactly one cycle
  always @(posedge clk) exp_rdy <= !rst && bus_valid && bus_sel && !bus_ready;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus_ready !== exp_rdy) begin
        failures++;
        $display("FAIL ready_timing: got %b expected %b at cycle %0d", bus_ready, exp_rdy, cyc);
      end
    end
  end

  // driver tasks: return at #1 after the edge that raises bus_ready
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk);
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    d = bus_rdata;
    bus_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] st);
    st = '0;
    for (int i = 0; i < 40 && !st[2]; i++) bus_rd(A_CTRL, st);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    checks++; if (bus_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", bus_ready); end
    checks++; if (bus_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", bus_rdata); end
    bus_rd(A_INFO, d);
    checks++; if (d !== 32'h0002_0408) begin failures++; $display("FAIL info: got %h expected 00020408", d); end
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_status: got %h expected 0", d); end
    bus_rd(A_POST, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL rst_post: got %h expected 8", d); end
    bus_rd(A_MASK, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mask: got %h expected 0", d); end
  endtask

  task automatic test_regs_unmapped;
    logic [31:0] d;
    bus_wr(A_MASK, 32'h1234_56A5);
    bus_rd(A_MASK, d);
    checks++; if (d !== 32'hA5) begin failures++; $display("FAIL mask_rw: got %h expected a5", d); end
    bus_wr(A_POST, 32'h13);
    bus_rd(A_POST, d);
    checks++; if (d !== 32'h3) begin failures++; $display("FAIL post_trunc: got %h expected 3", d); end
    bus_wr(32'hf818_0020, 32'hFFFF_FFFF);
    bus_rd(32'hf818_0020, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped: got %h expected 0", d); end
    bus_rd(A_RAM + 32'h40, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ram_oob: got %h expected 0", d); end
  endtask

  task automatic test_level_trigger;
    logic [31:0] d;
    use_ovr = 1'b0;
    bus_wr(A_MASK, 32'hFF);
    bus_wr(A_VALUE, 32'h20);
    bus_wr(A_POST, 32'h4);
    bus_wr(A_CTRL, 32'h01);
    base_cyc = cyc;
    wait_done(d);
    checks++; if (d !== 32'h0004_0006) begin failures++; $display("FAIL lvl_status: got %h expected 00040006", d); end
    bus_rd(A_IDX, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL lvl_idx: got %h expected 0", d); end
    bus_rd(A_RAM + 32'd0, d);
    checks++; if (d !== 32'h20) begin failures++; $display("FAIL lvl_ram0: got %h expected 20", d); end
    bus_rd(A_RAM + 32'd12, d);
    checks++; if (d !== 32'h23) begin failures++; $display("FAIL lvl_ram3: got %h expected 23", d); end
    bus_rd(A_RAM + 32'd60, d);
    checks++; if (d !== 32'h1F) begin failures++; $display("FAIL lvl_ram15: got %h expected 1f", d); end
    bus_rd(A_RAM + 32'd16, d);
    checks++; if (d !== 32'h14) begin failures++; $display("FAIL lvl_ram4: got %h expected 14", d); end
  endtask

  task automatic test_post_wrap;
    logic [31:0] d;
    bus_wr(A_MASK, 32'h00);
    bus_wr(A_POST, 32'd16);
    bus_rd(A_POST, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post16_stored: got %h expected 0", d); end
    bus_wr(A_CTRL, 32'h01);
    base_cyc = cyc;
    wait_done(d);
    checks++; if (d !== 32'h0000_0006) begin failures++; $display("FAIL post16_status: got %h expected 00000006", d); end
    bus_rd(A_IDX, d);
    checks++; if (d !== 32'hF) begin failures++; $display("FAIL post16_idx: got %h expected f", d); end
    bus_rd(A_RAM + 32'd60, d);
    checks++; if (d !== 32'h0F) begin failures++; $display("FAIL post16_ram15: got %h expected 0f", d); end
    bus_rd(A_RAM + 32'd0, d);
    checks++; if (d !== 32'h00) begin failures++; $display("FAIL post16_ram0: got %h expected 00", d); end
  endtask

  task automatic test_edge_trigger;
    logic [31:0] d;
    use_ovr = 1'b1;
    probe_ovr = 8'h01;
    bus_wr(A_MASK, 32'h01);
    bus_wr(A_VALUE, 32'h01);
    bus_wr(A_POST, 32'h4);
    bus_wr(A_CTRL, 32'h11);
    repeat (19) @(posedge clk);
    #1 probe_ovr = 8'h00;
    repeat (2) @(posedge clk);
    #1 probe_ovr = 8'h01;
    wait_done(d);
    checks++; if (d !== 32'h0009_0016) begin failures++; $display("FAIL edge_status: got %h expected 00090016", d); end
    bus_rd(A_IDX, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL edge_idx: got %h expected 5", d); end
    bus_rd(A_RAM + 32'd16, d);
    checks++; if (d !== 32'h00) begin failures++; $display("FAIL edge_ram4: got %h expected 00", d); end
    bus_rd(A_RAM + 32'd20, d);
    checks++; if (d !== 32'h01) begin failures++; $display("FAIL edge_ram5: got %h expected 01", d); end
    bus_rd(A_RAM + 32'd8, d);
    checks++; if (d !== 32'h01) begin failures++; $display("FAIL edge_ram2: got %h expected 01", d); end
    use_ovr = 1'b0;
  endtask

  task automatic test_stop_clear;
    logic [31:0] d;
    bus_wr(A_MASK, 32'hFF);
    bus_wr(A_VALUE, 32'hEE);
    bus_wr(A_POST, 32'h4);
    bus_wr(A_CTRL, 32'h01);
    base_cyc = cyc;
    repeat (18) @(posedge clk);
    bus_wr(A_CTRL, 32'h02);
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0004_0004) begin failures++; $display("FAIL stop_status: got %h expected 00040004", d); end
    repeat (5) @(posedge clk);
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0004_0004) begin failures++; $display("FAIL stop_frozen: got %h expected 00040004", d); end
    bus_rd(A_RAM + 32'd12, d);
    checks++; if (d !== 32'h13) begin failures++; $display("FAIL stop_ram3: got %h expected 13", d); end
    bus_rd(A_RAM + 32'd16, d);
    checks++; if (d !== 32'h04) begin failures++; $display("FAIL stop_ram4: got %h expected 04", d); end
    bus_wr(A_CTRL, 32'h07);
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_all: got %h expected 0", d); end
    bus_wr(A_CTRL, 32'h01);
    bus_wr(A_CTRL, 32'h03);
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0002_0004) begin failures++; $display("FAIL stop_over_arm: got %h expected 00020004", d); end
    bus_wr(A_CTRL, 32'h04);
  endtask

  task automatic test_reset_mid_capture;
    logic [31:0] d;
    bus_wr(A_MASK, 32'hFF);
    bus_wr(A_VALUE, 32'h03);
    bus_wr(A_POST, 32'hF);
    bus_wr(A_CTRL, 32'h01);
    base_cyc = cyc;
    repeat (4) @(posedge clk);
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0005_0003) begin failures++; $display("FAIL post_status: got %h expected 00050003", d); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus_ready !== 1'b0) begin failures++; $display("FAIL rst2_ready: got %b expected 0", bus_ready); end
    bus_rd(A_CTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst2_status: got %h expected 0", d); end
    bus_rd(A_MASK, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst2_mask: got %h expected 0", d); end
    bus_rd(A_VALUE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst2_value: got %h expected 0", d); end
    bus_rd(A_POST, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL rst2_post: got %h expected 8", d); end
    bus_rd(A_IDX, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst2_idx: got %h expected 0", d); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  rdy;
    logic [31:0] d0;
    @(posedge clk);
    @(negedge clk);
    bus_sel = 1'b0; bus_valid = 1'b1; bus_we = 1'b0; bus_addr = A_INFO;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_ready !== 1'b0) begin failures++; $display("FAIL no_sel: got %b expected 0", bus_ready); end
    bus_sel = 1'b1;
    d0 = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rdy[i] = bus_ready;
      if (i == 0) d0 = bus_rdata;
    end
    bus_valid = 1'b0;
    checks++; if (rdy !== 4'b0101) begin failures++; $display("FAIL b2b_ready: got %b expected 0101", rdy); end
    checks++; if (d0 !== 32'h0002_0408) begin failures++; $display("FAIL b2b_rdata: got %h expected 00020408", d0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs_unmapped();
    test_level_trigger();
    test_post_wrap();
    test_edge_trigger();
    test_stop_clear();
    test_reset_mid_capture();
    test_back_to_back();
    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ila_trig.md
Name: ila_trig

Overview:
- Second-generation integrated logic analyzer at BASE_ILA (0xf810_0000) on the CPU register bus.
- Parametrised in sample width and depth.
- Adds a masked value/edge trigger, a programmable post-trigger count and a recorded trigger index, so software can reconstruct a pre/post-trigger window from a circular sample RAM.
- Sits beside scratch RAM and reset control; probes come from any design clock-synchronous signal bundle.

Parameters:
- SAMPLE_W, 32, probe width in bits (1..32); RAM words are zero-extended to 32 on read.
- DEPTH_LOG2, 10, log2 of sample depth (4..16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- probe  in  SAMPLE_W  signals sampled every cycle
- bus_valid  in  1  request valid, held until bus_ready
- bus_addr  in  32  byte address
- bus_we  in  1  1 = write
- bus_wdata  in  32  write data (full-word writes only)
- bus_rdata  out  32  read data, valid when bus_ready
- bus_ready  out  1  one-cycle completion pulse
- bus_sel  in  1  decoded select for the 0xf81x_xxxx region

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: bus_ready=0, bus_rdata=0, state=IDLE, wr_ptr=0, trig_mask=0, trig_value=0, post_cnt=DEPTH/2, trig_idx=0, edge_mode=0.
- Bus timing: every access with bus_valid&bus_sel gets bus_ready exactly 1 cycle later (registered). bus_ready is never asserted for back-to-back cycles.
- Unmapped addresses read 0 and ignore writes.

Register map (offsets from BASE_ILA):
- 0x00000+4*i: sample RAM, read-only, physical index i.
- 0x80000 INFO (RO): [7:0]=SAMPLE_W, [15:8]=DEPTH_LOG2, [23:16]=2 (version).
- 0x80004 CTRL_STATUS:
  - Write: bit0=arm, bit1=stop, bit2=clear, bit4=edge_mode.
  - Read: bit0=armed (PRE/WAIT/POST), bit1=triggered, bit2=done, bit4=edge_mode, [31:16]=wr_ptr.
- 0x80008 TRIG_MASK: RW.
- 0x8000C TRIG_VALUE: RW.
- 0x80010 POST_CNT: RW, DEPTH_LOG2 bits; 0 is treated as 1.
- 0x80014 TRIG_IDX: RO, physical index of the trigger sample.

Trigger:
- match = (probe & mask) == (value & mask).
- Level mode: hit = match.
- Edge mode: hit = match & ~match_q.
- match_q is 0 on entering PRE.

FSM:
- IDLE: no capture. arm -> PRE, wr_ptr=0, pre_cnt=0.
- PRE: write probe at wr_ptr each cycle, wr_ptr++ (wraps modulo DEPTH). When pre_cnt reaches DEPTH-post_cnt -> WAIT. Hits are ignored in PRE.
- WAIT: keep writing. On hit: trig_idx=wr_ptr (sample of the hit cycle), remaining=post_cnt-1 -> POST.
- POST: write each cycle, decrement remaining. When remaining reaches 0 after the write -> DONE.
- DONE: no writes; triggered flag set.
- stop in PRE/WAIT/POST -> DONE with triggered=0.
- clear in any state -> IDLE, flags cleared.

Simultaneous events and boundaries:
- Control-bit priority in the same write: clear > stop > arm.
- arm in any non-IDLE state restarts PRE.
- Trigger register writes take effect the cycle after bus_ready.
- rst mid-capture returns to IDLE; RAM content is undefined but readable.
- RAM reads are legal in any state; a read returns the stored word, 1-cycle latency, with no read/write hazard guarantee outside DONE.

Decomposition:
- reg_map_pkg: add R_ILA_TRIG_MASK, R_ILA_TRIG_VALUE, R_ILA_POST_CNT, R_ILA_TRIG_IDX, and CTRL bit-position constants.
- ila_pkg: ila_state_t enum {IDLE, PRE, WAIT, POST, DONE}, ILA_VERSION=2.
- Sub-module ila_sample_ram: simple dual-port, 1 write/1 read, registered read, SAMPLE_W x 2^DEPTH_LOG2, inferable as BRAM.

Test Plan (SAMPLE_W=8, DEPTH_LOG2=4, probe = free-running 8-bit counter starting at 0 on arm cycle):
- Read INFO -> 0x0002_0408; CTRL_STATUS after reset -> 0x0000_0000.
- mask=0xFF, value=0x20, post=4, level; arm -> done=1, triggered=1, TRIG_IDX=0x0, RAM[0]=0x20, RAM[3]=0x23, RAM[15]=0x1F, RAM[4]=0x14.
- mask=0x00, post=16 (stored as 0 -> 1); arm -> trigger immediately after 15 pre samples, TRIG_IDX=15, done after 16 total writes.
- Edge mode, mask=0x01, value=0x01, probe bit0 held 1 from arm -> no trigger until bit0 drops and re-rises; TRIG_IDX points at the rise sample.
- Arm, then stop during WAIT -> done=1, triggered=0, wr_ptr frozen; then write arm|stop|clear together -> IDLE, status 0.
- Assert rst during POST -> next cycle state IDLE, registers at reset values; bus_ready exactly one cycle after each bus_valid throughout.
